// File: rtl/mna_response_depacketizer.sv
// Reassembles head+tail response flits into records and buffers them in a FWFT FIFO.
// Optional flit parity checking is enabled by defining MNA_RESP_PARITY_EN.
module mna_response_depacketizer #(
  parameter int DEPTH      = 4,
  parameter int OFF_MARGIN = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [34:0] flit_in,
  input  logic        flit_valid,
  output logic        on_off,
  output logic        allocatable,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_write,
  output logic [1:0]  resp_code,
  output logic [3:0]  resp_id,
  output logic [31:0] resp_data,
  output logic        overflow,
  output logic        fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] OFF_C   = CW'(OFF_MARGIN);

  localparam logic [0:0] WAIT_HEAD = 1'b0;
  localparam logic [0:0] WAIT_TAIL = 1'b1;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic [0:0]    state, state_next;
  logic          hdr_write;
  logic [1:0]    hdr_code;
  logic [3:0]    hdr_id;
  logic          hdr_latch;
  logic          push, pop, full, wr_en, drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [38:0]   mem [DEPTH];
  logic [38:0]   rec, head_rec;
  logic [1:0]    flit_type;
  logic          flit_act;
  logic          flit_bad;
  logic          unused_bits;

  assign flit_type = flit_in[33:32];
  assign flit_act  = flit_valid && (flit_type != T_IDLE);

`ifdef MNA_RESP_PARITY_EN
  logic hdr_corrupt;
  // Even parity: XOR over all 35 bits must be zero.
  assign flit_bad    = ^flit_in;
  assign unused_bits = ^flit_in[24:0];
`else
  assign flit_bad    = 1'b0;
  assign unused_bits = ^{flit_in[34], flit_in[24:0], flit_bad};
`endif

  always_comb begin
    state_next = state;
    hdr_latch  = 1'b0;
    push       = 1'b0;
    if (flit_act) begin
      case (state)
        WAIT_HEAD: begin
          if (flit_type == T_HEAD) begin
            hdr_latch  = 1'b1;
            state_next = WAIT_TAIL;
          end
        end
        default: begin
          case (flit_type)
            T_TAIL: begin
              push       = 1'b1;
              state_next = WAIT_HEAD;
            end
            T_HEAD:  hdr_latch  = 1'b1;
            T_BODY:  state_next = WAIT_HEAD;
            default: state_next = state;
          endcase
        end
      endcase
    end
  end

  // Record layout: {write, code[1:0], id[3:0], data[31:0]}.
  always_comb begin
    rec = {hdr_write, hdr_code, hdr_id, (hdr_write ? 32'h0 : flit_in[31:0])};
`ifdef MNA_RESP_PARITY_EN
    if (flit_bad || hdr_corrupt) begin
      rec[37:36] = 2'b10;
      rec[31:0]  = 32'h0;
    end
`endif
  end

  // Handshake: a record transfers on any rising edge where resp_valid and
  // resp_ready are both 1; resp_valid depends only on registered count, and
  // resp_* stay constant while resp_valid=1 and resp_ready=0.
  assign pop   = resp_valid && resp_ready;
  assign full  = (count == DEPTH_C);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= WAIT_HEAD;
      hdr_write <= 1'b0;
      hdr_code  <= 2'b00;
      hdr_id    <= 4'h0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      if (hdr_latch) begin
        hdr_write <= flit_in[31];
        hdr_code  <= flit_in[30:29];
        hdr_id    <= flit_in[28:25];
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef MNA_RESP_PARITY_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)       hdr_corrupt <= 1'b0;
    else if (hdr_latch) hdr_corrupt <= flit_bad;
  end
`endif

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= rec;
  end

  assign head_rec    = mem[rd_ptr];
  assign resp_valid  = (count != '0);
  assign resp_write  = resp_valid ? head_rec[38]    : 1'b0;
  assign resp_code   = resp_valid ? head_rec[37:36] : 2'b00;
  assign resp_id     = resp_valid ? head_rec[35:32] : 4'h0;
  assign resp_data   = resp_valid ? head_rec[31:0]  : 32'h0;
  assign on_off      = (DEPTH_C - count) > OFF_C;
  assign allocatable = (state == WAIT_HEAD) && (count < DEPTH_C);
  assign fsm_state   = state;

endmodule

// File: tb/tb_mna_response_depacketizer.sv
// Bench for mna_response_depacketizer: queue-based packet model plus directed literal checks.
module tb_mna_response_depacketizer;
  localparam int DEPTH      = 4;
  localparam int OFF_MARGIN = 1;
`ifdef MNA_RESP_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [34:0] flit_in = '0;
  logic        flit_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic        on_off, allocatable, resp_valid, resp_write, overflow, fsm_state;
  logic [1:0]  resp_code;
  logic [3:0]  resp_id;
  logic [31:0] resp_data;

  mna_response_depacketizer #(.DEPTH(DEPTH), .OFF_MARGIN(OFF_MARGIN)) dut (
    .aclk(aclk), .aresetn(aresetn), .flit_in(flit_in), .flit_valid(flit_valid),
    .on_off(on_off), .allocatable(allocatable), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_write(resp_write), .resp_code(resp_code),
    .resp_id(resp_id), .resp_data(resp_data), .overflow(overflow),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] mk(input logic [1:0] t, input logic [31:0] p, input bit bad);
    logic par;
    par = (^{t, p}) ^ bad;
    return {par, t, p};
  endfunction

  // behavioural model: records as {write, code, id, data}
  logic [38:0] exp_q[$];
  bit          m_in_pkt;
  logic        m_hw;
  logic [1:0]  m_hc;
  logic [3:0]  m_hid;
  bit          m_hbad;
  bit          m_ovf;

  always @(posedge aclk or negedge aresetn) begin
    bit          pop, full, bad;
    logic [38:0] r;
    if (!aresetn) begin
      exp_q.delete();
      m_in_pkt = 0;
      m_hbad   = 0;
      m_ovf    = 0;
    end else begin
      full = (exp_q.size() == DEPTH);
      pop  = (exp_q.size() != 0) && resp_ready;
      if (pop) void'(exp_q.pop_front());
      if (flit_valid && flit_in[33:32] != 2'b00) begin
        bad = PAR_EN && ((^flit_in) != 1'b0);
        case (flit_in[33:32])
          2'b01: begin
            m_in_pkt = 1;
            m_hw     = flit_in[31];
            m_hc     = flit_in[30:29];
            m_hid    = flit_in[28:25];
            m_hbad   = bad;
          end
          2'b10: m_in_pkt = 0;
          default: begin
            if (m_in_pkt) begin
              m_in_pkt = 0;
              r = {m_hw, m_hc, m_hid, (m_hw ? 32'h0 : flit_in[31:0])};
              if (bad || m_hbad) begin
                r[37:36] = 2'b10;
                r[31:0]  = 32'h0;
              end
              if (full && !pop) m_ovf = 1;
              else exp_q.push_back(r);
            end
          end
        endcase
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge aclk) begin
    check("resp_valid", resp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0)
      check("resp_rec", {resp_write, resp_code, resp_id, resp_data}, exp_q[0]);
    check("on_off", on_off, (DEPTH - exp_q.size()) > OFF_MARGIN);
    check("allocatable", allocatable, !m_in_pkt && (exp_q.size() < DEPTH));
    check("overflow", overflow, m_ovf);
  end

  // driver tasks
  task automatic send(input logic [1:0] t, input logic [31:0] p, input bit bad = 0);
    @(posedge aclk); #1;
    flit_in    = mk(t, p, bad);
    flit_valid = 1'b1;
  endtask

  task automatic head(input logic w, input logic [1:0] c, input logic [3:0] id, input bit bad = 0);
    send(2'b01, {w, c, id, 25'h0}, bad);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
      flit_valid = 1'b0;
      flit_in    = '0;
    end
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_write", resp_write, 1'b0);
    check("rst_code", resp_code, 2'b00);
    check("rst_id", resp_id, 4'h0);
    check("rst_data", resp_data, 32'h0);
    check("rst_on_off", on_off, 1'b1);
    check("rst_alloc", allocatable, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    @(posedge aclk); #1 aresetn = 1'b1;

    // read response
    resp_ready = 1'b1;
    send(2'b01, 32'h1A00_0000);
    send(2'b11, 32'hDEAD_BEEF);
    idle(1);
    @(negedge aclk);
    check("rd_valid", resp_valid, 1'b1);
    check("rd_write", resp_write, 1'b0);
    check("rd_code", resp_code, 2'b00);
    check("rd_id", resp_id, 4'hD);
    check("rd_data", resp_data, 32'hDEAD_BEEF);
    idle(1);
    @(negedge aclk);
    check("rd_popped", resp_valid, 1'b0);

    // write response
    resp_ready = 1'b0;
    send(2'b01, 32'hA000_0000);
    send(2'b11, 32'h1234_5678);
    idle(1);
    @(negedge aclk);
    check("wr_write", resp_write, 1'b1);
    check("wr_code", resp_code, 2'b01);
    check("wr_data", resp_data, 32'h0);
    @(posedge aclk); #1 resp_ready = 1'b1;
    idle(2);

    // fill and stall, then overflow, then drain
    resp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      head(1'b0, 2'b00, 4'(i));
      send(2'b11, 32'(i));
    end
    idle(1);
    @(negedge aclk);
    check("full_on_off", on_off, 1'b0);
    check("full_alloc", allocatable, 1'b0);
    head(1'b0, 2'b00, 4'd5);
    send(2'b11, 32'd5);
    idle(1);
    @(negedge aclk);
    check("ovf_set", overflow, 1'b1);
    @(posedge aclk); #1 resp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge aclk);
      check("drain_data", resp_data, 32'(i));
    end
    idle(2);

    // stray tail
    send(2'b11, 32'h7777_7777);
    idle(1);
    @(negedge aclk);
    check("stray_tail", resp_valid, 1'b0);

    // head, head, tail keeps the second header
    head(1'b0, 2'b00, 4'd1);
    head(1'b0, 2'b11, 4'd2);
    send(2'b11, 32'hCAFE_0000);
    idle(1);
    @(negedge aclk);
    check("hht_id", resp_id, 4'd2);
    check("hht_code", resp_code, 2'b11);
    idle(2);

    // head, body, tail yields nothing
    head(1'b0, 2'b00, 4'd3);
    send(2'b10, 32'h0);
    send(2'b11, 32'h1111_1111);
    idle(1);
    @(negedge aclk);
    check("hbt_none", resp_valid, 1'b0);

    // reset pulse between head and tail
    head(1'b0, 2'b00, 4'd7);
    @(posedge aclk); #1;
    flit_valid = 1'b0;
    aresetn    = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    send(2'b11, 32'h2222_2222);
    idle(1);
    @(negedge aclk);
    check("rstmid_none", resp_valid, 1'b0);
    check("rstmid_ovf", overflow, 1'b0);

    // push and pop in the same cycle while full
    resp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      head(1'b1, 2'b01, 4'(i));
      send(2'b11, 32'hFFFF_FFFF);
    end
    head(1'b0, 2'b00, 4'd9);
    send(2'b11, 32'h9999_0000);
    resp_ready = 1'b1;
    idle(1);
    @(negedge aclk);
    check("fullpp_ovf", overflow, 1'b0);
    idle(6);

    // parity: bad tail
    head(1'b0, 2'b00, 4'd3);
    send(2'b11, 32'h55AA_55AA, 1);
    idle(1);
    @(negedge aclk);
    check("par_tail_code", resp_code, PAR_EN ? 2'b10 : 2'b00);
    check("par_tail_data", resp_data, PAR_EN ? 32'h0 : 32'h55AA_55AA);
    idle(1);

    // parity: bad head, good tail
    head(1'b0, 2'b01, 4'd4, 1);
    send(2'b11, 32'h0000_0011);
    idle(1);
    @(negedge aclk);
    check("par_head_code", resp_code, PAR_EN ? 2'b10 : 2'b01);
    check("par_head_data", resp_data, PAR_EN ? 32'h0 : 32'h11);
    idle(1);

    // back-to-back packets
    for (int i = 0; i < 3; i++) begin
      head(1'(i), 2'(i), 4'(i + 10));
      send(2'b11, 32'hA5A5_0000 + 32'(i));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
